// File: rtl/simd_mul_sched.sv
// simd_mul_sched: round-robin scheduler sharing one combinational 8-bit SIMD
// multiplier between two requesters, with a tagged valid/ready response port.
module simd_mul_sched #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [1:0]       req1_mode,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    output logic             mul_h,
    output logic             mul_x,
    output logic             mul_c,
    input  logic [7:0]       mul_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           rr_ptr;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [MW-1:0]  mode_q;
    logic           id_q;

    logic           accept;
    logic           gnt;
    logic           gnt_id;
    logic [DW-1:0]  gnt_a;
    logic [DW-1:0]  gnt_b;
    logic [MW-1:0]  gnt_mode;

    // Round-robin arbitration inside the accept window; ready is a same-cycle grant.
    always_comb begin
        accept   = (state == IDLE) || ((state == DONE) && rsp_ready);
        gnt      = accept && (req0_valid || req1_valid);
        gnt_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        gnt_a    = gnt_id ? req1_a    : req0_a;
        gnt_b    = gnt_id ? req1_b    : req0_b;
        gnt_mode = gnt_id ? req1_mode : req0_mode;
        req0_ready = gnt && !gnt_id;
        req1_ready = gnt && gnt_id;
    end

    // Lane-mode decode from the captured mode only, so selects are stable in EXEC.
    always_comb begin
        mul_h = 1'b0;
        mul_x = 1'b0;
        mul_c = 1'b0;
        case (mode_q)
            2'b00:   mul_h = 1'b1;
            2'b01:   mul_x = 1'b1;
            2'b11:   mul_c = 1'b1;
            default: ;
        endcase
    end

    assign mul_a = a_q;
    assign mul_b = b_q;
    assign busy  = (state != IDLE);

    // Scheduler FSM: capture on grant, one-cycle execute, hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= mul_result;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= gnt ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (gnt) begin
                a_q    <= gnt_a;
                b_q    <= gnt_b;
                mode_q <= gnt_mode;
                id_q   <= gnt_id;
                rr_ptr <= ~gnt_id;
                if (!gnt_id && (cnt0 != CNT_MAX)) begin
                    cnt0 <= cnt0 + CNT_W'(1);
                end
                if (gnt_id && (cnt1 != CNT_MAX)) begin
                    cnt1 <= cnt1 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_mul_sched.sv
// Directed bench for simd_mul_sched: vector table plus multi-cycle sequences.
module tb_simd_mul_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_mode, req1_mode;
    logic       rsp_ready;

    logic       req0_ready, req1_ready;
    logic [7:0] mul_a, mul_b, mul_result, rsp_data;
    logic       mul_h, mul_x, mul_c, rsp_valid, rsp_id, busy;
    logic [7:0] cnt0, cnt1;

    logic       s_req0_ready, s_req1_ready;
    logic [7:0] s_mul_a, s_mul_b, s_mul_result, s_rsp_data;
    logic       s_mul_h, s_mul_x, s_mul_c, s_rsp_valid, s_rsp_id, s_busy;
    logic [1:0] s_cnt0, s_cnt1;

    int checks = 0;
    int errors = 0;

    // Multiplier stubs: XOR of operands keeps expected data easy to derive.
    assign mul_result   = mul_a ^ mul_b;
    assign s_mul_result = s_mul_a ^ s_mul_b;

    simd_mul_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
        .mul_a(mul_a), .mul_b(mul_b), .mul_h(mul_h), .mul_x(mul_x), .mul_c(mul_c),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    simd_mul_sched #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
        .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_h(s_mul_h), .mul_x(s_mul_x), .mul_c(s_mul_c),
        .mul_result(s_mul_result),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
        .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic [2:0] hxc;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] mode);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = mode;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = mode;
        end
    endtask

    // One complete op from IDLE with the consumer always ready; called just after a negedge.
    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] mode, input logic [2:0] hxc, input logic [7:0] data);
        rsp_ready = 1'b1;
        drive(id, a, b, mode);
        #1;
        chk("grant_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        chk("other_ready", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("exec_hxc", {29'd0, mul_h, mul_x, mul_c}, {29'd0, hxc});
        chk("exec_operands", {16'd0, mul_a, mul_b}, {16'd0, a, b});
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, data});
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, id});
        @(negedge clk);
        chk("back_idle", {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int ng, nr, cyc;
        logic exp_g, exp_r;
        logic [7:0] hold_data;

        vecs[0] = '{id: 1'b0, a: 8'hff, b: 8'h0f, mode: 2'b00, hxc: 3'b100, data: 8'hf0};
        vecs[1] = '{id: 1'b1, a: 8'ha5, b: 8'h5a, mode: 2'b01, hxc: 3'b010, data: 8'hff};
        vecs[2] = '{id: 1'b0, a: 8'h81, b: 8'h18, mode: 2'b10, hxc: 3'b000, data: 8'h99};
        vecs[3] = '{id: 1'b1, a: 8'h7e, b: 8'h7e, mode: 2'b11, hxc: 3'b001, data: 8'h00};

        req0_a = '0; req0_b = '0; req0_mode = '0;
        req1_a = '0; req1_b = '0; req1_mode = '0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_counts", {16'd0, cnt0, cnt1}, 32'd0);
        chk("rst_hxc", {29'd0, mul_h, mul_x, mul_c}, 32'd4);
        chk("rst_data", {15'd0, mul_a, mul_b, rsp_id}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        do_reset();

        // Single op, mode 01.
        issue(1'b0, 8'h12, 8'h34, 2'b01, 3'b010, 8'h26);
        chk("single_cnt0", {24'd0, cnt0}, 32'd1);

        // Mode decode table, alternating requesters.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].hxc, vecs[i].data);
        end
        chk("table_counts", {16'd0, cnt0, cnt1}, {16'd0, 8'd3, 8'd2});

        // Contention: both valid continuously, consumer always ready.
        do_reset();
        rsp_ready = 1'b1;
        drive(1'b0, 8'h11, 8'h22, 2'b00);
        drive(1'b1, 8'h40, 8'h04, 2'b00);
        ng = 0; nr = 0; exp_g = 1'b0; exp_r = 1'b0;
        for (cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            #1;
            chk("one_hot_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_ready || req1_ready) begin
                chk("rr_grant", {31'd0, req1_ready}, {31'd0, exp_g});
                exp_g = ~exp_g;
                ng++;
            end
            if (rsp_valid && rsp_ready) begin
                chk("rr_rsp_id", {31'd0, rsp_id}, {31'd0, exp_r});
                chk("rr_rsp_data", {24'd0, rsp_data}, exp_r ? 32'h44 : 32'h33);
                exp_r = ~exp_r;
                nr++;
                if (nr == 4) begin
                    chk("rr_counts", {16'd0, cnt0, cnt1}, {16'd0, 8'd2, 8'd2});
                end
            end
            @(negedge clk);
        end
        chk("rr_responses", nr, 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure with req1 pending behind a held response.
        do_reset();
        rsp_ready = 1'b0;
        drive(1'b0, 8'h01, 8'h02, 2'b00);
        drive(1'b1, 8'hf0, 8'h0f, 2'b10);
        #1;
        chk("bp_first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h03});
        hold_data = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {22'd0, rsp_valid, rsp_id, rsp_data}, {22'd0, 1'b1, 1'b0, hold_data});
            chk("bp_no_grant", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("bp_exec", {28'd0, rsp_valid, mul_h, mul_x, mul_c}, 32'd0);
        @(negedge clk);
        chk("bp_rsp2", {22'd0, rsp_valid, rsp_id, rsp_data}, {22'd0, 1'b1, 1'b1, 8'hff});
        @(negedge clk);

        // Reset while holding a response.
        rsp_ready = 1'b0;
        drive(1'b0, 8'h55, 8'h0f, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_rsp", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {14'd0, rsp_valid, busy, cnt0, cnt1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_quiet", {30'd0, rsp_valid, busy}, 32'd0);
        end

        // Saturation of the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 8'(i), 8'h80, 2'b10, 3'b000, 8'(i) ^ 8'h80);
            if (i == 2) begin
                chk("sat_at3", {30'd0, s_cnt0}, 32'd3);
            end
        end
        chk("sat_hold", {30'd0, s_cnt0}, 32'd3);
        chk("wide_cnt0", {24'd0, cnt0}, 32'd5);
        chk("sat_cnt1", {30'd0, s_cnt1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
